// File: rtl/e203_ifu_bht_arb_pkg.sv
// Shared types and constants for the IFU branch-history-table port arbiter.
package e203_ifu_bht_arb_pkg;

   localparam int unsigned E203_PC_SIZE     = 32;
   localparam int unsigned E203_BHT_IDX_W   = 6;
   localparam int unsigned E203_BHT_FIFO_DP = 4;

   // 2-bit branch counter states
   typedef enum logic [1:0] {
      BHT_SNT = 2'd0,
      BHT_WNT = 2'd1,
      BHT_WT  = 2'd2,
      BHT_ST  = 2'd3
   } bht_cnt_e;

   // Read-modify-write sequencer states
   typedef enum logic [1:0] {
      UPD_IDLE,
      UPD_RD,
      UPD_CAP,
      UPD_WR
   } upd_state_e;

   // Saturating 2-bit counter step toward the resolved outcome
   function automatic logic [1:0] bht_sat(input logic [1:0] cnt, input logic taken);
      logic [1:0] res;
      res = cnt;
      if (taken && (cnt != BHT_ST)) begin
         res = cnt + 2'd1;
      end else if (!taken && (cnt != BHT_SNT)) begin
         res = cnt - 2'd1;
      end
      return res;
   endfunction

endpackage

// File: rtl/sirv_gnrl_fifo.sv
// Generic flop-based FIFO; CUT_READY=1 makes i_rdy depend only on registered occupancy.
module sirv_gnrl_fifo #(
   parameter int unsigned CUT_READY = 0,
   parameter int unsigned DP        = 8,
   parameter int unsigned DW        = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_vld,
   output logic          i_rdy,
   input  logic [DW-1:0] i_dat,
   output logic          o_vld,
   input  logic          o_rdy,
   output logic [DW-1:0] o_dat
);

   localparam int unsigned AW = (DP > 1) ? $clog2(DP) : 1;
   localparam int unsigned CW = $clog2(DP + 1);

   logic [DW-1:0] mem_q [DP];
   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          full;
   logic          push;
   logic          pop;

   assign full = (cnt_q == CW'(DP));

   generate
      if (CUT_READY != 0) begin : g_cut
         assign i_rdy = !full;
      end else begin : g_pass
         assign i_rdy = !full || o_rdy;
      end
   endgenerate

   assign o_vld = (cnt_q != '0);
   assign o_dat = mem_q[rptr_q];
   assign push  = i_vld && i_rdy;
   assign pop   = o_vld && o_rdy;

   // Pointer and occupancy next-state
   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q + CW'(push) - CW'(pop);
      if (push) begin
         wptr_d = (wptr_q == AW'(DP - 1)) ? '0 : wptr_q + AW'(1);
      end
      if (pop) begin
         rptr_d = (rptr_q == AW'(DP - 1)) ? '0 : rptr_q + AW'(1);
      end
   end

   // Pointer and occupancy registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

   // Payload storage; contents are meaningless while the slot is empty
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wptr_q] <= i_dat;
      end
   end

endmodule

// File: rtl/e203_ifu_bht_arb.sv
// Branch-history-table port arbiter: lookups from the IFU share the single
// table port with queued read-modify-write counter updates from commit.
module e203_ifu_bht_arb
   import e203_ifu_bht_arb_pkg::*;
#(
   parameter int unsigned IDX_W      = E203_BHT_IDX_W,
   parameter int unsigned FIFO_DP    = E203_BHT_FIFO_DP,
   parameter int unsigned STARVE_MAX = 3
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    lkup_vld,
   input  logic [E203_PC_SIZE-1:0] lkup_pc,
   output logic                    lkup_rdy,
   output logic                    lkup_rsp_vld,
   output logic                    lkup_rsp_taken,
   input  logic                    upd_vld,
   input  logic [E203_PC_SIZE-1:0] upd_pc,
   input  logic                    upd_taken,
   output logic                    upd_rdy,
   output logic                    tbl_cs,
   output logic                    tbl_we,
   output logic [IDX_W-1:0]        tbl_addr,
   output logic [1:0]              tbl_wdata,
   input  logic [1:0]              tbl_rdata
);

   localparam int unsigned SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

   upd_state_e     state_q, state_d;
   logic [SW-1:0]  starve_q, starve_d;
   logic [1:0]     cnt_q, cnt_d;
   logic           rsp_vld_q, rsp_vld_d;

   logic           fifo_i_rdy;
   logic           fifo_o_vld;
   logic           fifo_o_rdy;
   logic [IDX_W:0] fifo_o_dat;
   logic [IDX_W-1:0] head_idx;
   logic           head_taken;
   logic           upd_push;
   logic           upd_req;
   logic           upd_force;
   logic           lkup_gnt;
   logic           upd_gnt;
   logic           unused_pc_bits;

   assign unused_pc_bits = ^{lkup_pc[E203_PC_SIZE-1:IDX_W+1], lkup_pc[0],
                             upd_pc[E203_PC_SIZE-1:IDX_W+1], upd_pc[0]};

   sirv_gnrl_fifo #(
      .CUT_READY (1),
      .DP        (FIFO_DP),
      .DW        (IDX_W + 1)
   ) u_upd_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .i_vld (upd_vld),
      .i_rdy (fifo_i_rdy),
      .i_dat ({upd_pc[IDX_W:1], upd_taken}),
      .o_vld (fifo_o_vld),
      .o_rdy (fifo_o_rdy),
      .o_dat (fifo_o_dat)
   );

   assign upd_rdy        = fifo_i_rdy;
   assign upd_push       = upd_vld && fifo_i_rdy;
   assign head_idx       = fifo_o_dat[IDX_W:1];
   assign head_taken     = fifo_o_dat[0];
   assign lkup_rsp_vld   = rsp_vld_q;
   assign lkup_rsp_taken = tbl_rdata[1];

   // Port arbitration and table drive
   always_comb begin
      upd_req   = (state_q == UPD_RD) || (state_q == UPD_WR);
      upd_force = (starve_q == SW'(STARVE_MAX));
      lkup_rdy  = !(lkup_vld && upd_req && upd_force);
      lkup_gnt  = lkup_vld && lkup_rdy;
      upd_gnt   = upd_req && !lkup_gnt;
      tbl_cs    = 1'b0;
      tbl_we    = 1'b0;
      tbl_addr  = '0;
      tbl_wdata = '0;
      if (lkup_gnt) begin
         tbl_cs   = 1'b1;
         tbl_addr = lkup_pc[IDX_W:1];
      end else if (upd_gnt) begin
         tbl_cs   = 1'b1;
         tbl_addr = head_idx;
         if (state_q == UPD_WR) begin
            tbl_we    = 1'b1;
            tbl_wdata = bht_sat(cnt_q, head_taken);
         end
      end
   end

   // Update sequencer next-state and starvation counting
   always_comb begin
      state_d    = state_q;
      starve_d   = starve_q;
      cnt_d      = cnt_q;
      fifo_o_rdy = 1'b0;
      rsp_vld_d  = lkup_gnt;
      unique case (state_q)
         UPD_IDLE: begin
            starve_d = '0;
            // A push into an empty queue starts the read in the very next cycle
            if (fifo_o_vld || upd_push) begin
               state_d = UPD_RD;
            end
         end
         UPD_RD: begin
            if (upd_gnt) begin
               state_d  = UPD_CAP;
               starve_d = '0;
            end else if (!upd_force) begin
               starve_d = starve_q + SW'(1);
            end
         end
         UPD_CAP: begin
            cnt_d   = tbl_rdata;
            state_d = UPD_WR;
         end
         UPD_WR: begin
            if (upd_gnt) begin
               fifo_o_rdy = 1'b1;
               state_d    = UPD_IDLE;
               starve_d   = '0;
            end else if (!upd_force) begin
               starve_d = starve_q + SW'(1);
            end
         end
         default: begin
            state_d = UPD_IDLE;
         end
      endcase
   end

   // Sequencer, starvation, captured counter and response registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= UPD_IDLE;
         starve_q  <= '0;
         cnt_q     <= '0;
         rsp_vld_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         starve_q  <= starve_d;
         cnt_q     <= cnt_d;
         rsp_vld_q <= rsp_vld_d;
      end
   end

endmodule

// File: tb/tb_e203_ifu_bht_arb.sv
// Bench for e203_ifu_bht_arb: behavioural single-port table plus a queue-level
// reference of accepted resolutions, directed scenarios then random traffic.
module tb_e203_ifu_bht_arb;
   import e203_ifu_bht_arb_pkg::*;

   localparam int IDX_W      = 6;
   localparam int FIFO_DP    = 4;
   localparam int STARVE_MAX = 3;
   localparam int NENT       = 64;

   typedef struct {
      int idx;
      bit taken;
   } upd_t;

   logic                    clk = 1'b0;
   logic                    rst_n;
   logic                    lkup_vld;
   logic [E203_PC_SIZE-1:0] lkup_pc;
   logic                    lkup_rdy;
   logic                    lkup_rsp_vld;
   logic                    lkup_rsp_taken;
   logic                    upd_vld;
   logic [E203_PC_SIZE-1:0] upd_pc;
   logic                    upd_taken;
   logic                    upd_rdy;
   logic                    tbl_cs;
   logic                    tbl_we;
   logic [IDX_W-1:0]        tbl_addr;
   logic [1:0]              tbl_wdata;
   logic [1:0]              tbl_rdata;

   logic [1:0] mem     [NENT];
   logic [1:0] ref_tbl [NENT];
   upd_t       q[$];
   bit         head_rd, rsp_pend, rsp_exp, prev_stall;
   int         gap, stall;
   int         vectors = 0;
   int         errs = 0;
   bit         rdy_pat [0:10];

   always #5 clk = ~clk;

   e203_ifu_bht_arb #(
      .IDX_W      (IDX_W),
      .FIFO_DP    (FIFO_DP),
      .STARVE_MAX (STARVE_MAX)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .lkup_vld       (lkup_vld),
      .lkup_pc        (lkup_pc),
      .lkup_rdy       (lkup_rdy),
      .lkup_rsp_vld   (lkup_rsp_vld),
      .lkup_rsp_taken (lkup_rsp_taken),
      .upd_vld        (upd_vld),
      .upd_pc         (upd_pc),
      .upd_taken      (upd_taken),
      .upd_rdy        (upd_rdy),
      .tbl_cs         (tbl_cs),
      .tbl_we         (tbl_we),
      .tbl_addr       (tbl_addr),
      .tbl_wdata      (tbl_wdata),
      .tbl_rdata      (tbl_rdata)
   );

   function automatic int idx_of(input logic [31:0] pc);
      return int'((pc >> 1) % NENT);
   endfunction

   function automatic logic [31:0] pc_of(input int idx);
      return ($urandom & 32'hFFFF_FF80) | (32'(idx) << 1) | ($urandom & 32'h1);
   endfunction

   function automatic int sat_ref(input int c, input bit t);
      if (t) return (c + 1 > 3) ? 3 : c + 1;
      return (c - 1 < 0) ? 0 : c - 1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic preset(input int idx, input int val);
      mem[idx]     = 2'(val);
      ref_tbl[idx] = 2'(val);
   endtask

   task automatic model_reset();
      q.delete();
      head_rd    = 0;
      rsp_pend   = 0;
      gap        = 0;
      stall      = 0;
      prev_stall = 0;
   endtask

   // Per-cycle protocol checks against the queue-level reference
   task automatic model_check();
      bit   exp_rdy, upd_access;
      upd_t head, nu;
      int   wv;
      exp_rdy = (q.size() < FIFO_DP);
      chk("upd_rdy", 32'(upd_rdy), 32'(exp_rdy));
      if (!lkup_vld) chk("lkup_rdy_novld", 32'(lkup_rdy), 32'd1);
      if (lkup_vld && q.size() == 0) chk("lkup_rdy_noupd", 32'(lkup_rdy), 32'd1);
      stall = (lkup_vld && !lkup_rdy) ? stall + 1 : 0;
      chk("stall_bound", 32'(stall <= 1), 32'd1);
      chk("rsp_vld", 32'(lkup_rsp_vld), 32'(rsp_pend));
      if (rsp_pend) chk("rsp_taken", 32'(lkup_rsp_taken), 32'(rsp_exp));
      rsp_pend   = 0;
      upd_access = 0;
      if (lkup_vld && lkup_rdy) begin
         chk("lk_cs", 32'(tbl_cs), 32'd1);
         chk("lk_we", 32'(tbl_we), 32'd0);
         chk("lk_addr", 32'(tbl_addr), 32'(idx_of(lkup_pc)));
         rsp_pend = 1;
         rsp_exp  = mem[idx_of(lkup_pc)][1];
      end else if (q.size() == 0) begin
         chk("quiet_cs", 32'(tbl_cs), 32'd0);
      end else if (tbl_cs) begin
         head       = q[0];
         upd_access = 1;
         chk("upd_addr", 32'(tbl_addr), 32'(head.idx));
         if (!head_rd) begin
            chk("upd_rd_we", 32'(tbl_we), 32'd0);
            head_rd = 1;
         end else begin
            chk("upd_wr_we", 32'(tbl_we), 32'd1);
            wv = sat_ref(int'(ref_tbl[head.idx]), head.taken);
            chk("upd_wdata", 32'(tbl_wdata), 32'(wv));
            ref_tbl[head.idx] = 2'(wv);
            void'(q.pop_front());
            head_rd = 0;
         end
      end
      if (upd_access) gap = 0;
      else if (q.size() > 0) gap++;
      chk("upd_progress", 32'(gap <= STARVE_MAX + 1), 32'd1);
      if (upd_vld && exp_rdy) begin
         nu.idx   = idx_of(upd_pc);
         nu.taken = upd_taken;
         q.push_back(nu);
      end
      prev_stall = lkup_vld && !lkup_rdy;
   endtask

   task automatic sample();
      #3;
      if (rst_n) model_check();
   endtask

   // Clock edge plus the behavioural single-port table
   task automatic advance();
      logic cs, we;
      logic [IDX_W-1:0] a;
      logic [1:0] wd;
      cs = tbl_cs; we = tbl_we; a = tbl_addr; wd = tbl_wdata;
      @(posedge clk);
      #1;
      if (cs) begin
         if (we) mem[a] = wd;
         else    tbl_rdata = mem[a];
      end
   endtask

   task automatic cyc();
      sample();
      advance();
   endtask

   // Continuous lookup stream; the IFU holds its request while stalled
   task automatic drive_lkup_cont();
      lkup_vld = 1'b1;
      if (!prev_stall) lkup_pc = pc_of($urandom_range(0, NENT - 1));
   endtask

   task automatic drain(input bit keep_lkup);
      upd_vld = 1'b0;
      if (!keep_lkup) lkup_vld = 1'b0;
      for (int i = 0; i < 200 && q.size() > 0; i++) begin
         if (keep_lkup) drive_lkup_cont();
         cyc();
      end
      chk("drain_done", 32'(q.size()), 32'd0);
      lkup_vld = 1'b0;
      cyc();
   endtask

   initial begin
      rdy_pat   = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1};
      rst_n     = 1'b0;
      lkup_vld  = 1'b0;
      lkup_pc   = '0;
      upd_vld   = 1'b0;
      upd_pc    = '0;
      upd_taken = 1'b0;
      tbl_rdata = '0;
      for (int i = 0; i < NENT; i++) preset(i, int'($urandom_range(0, 3)));
      model_reset();

      // Reset state
      @(posedge clk); #1;
      #3;
      chk("rst_cs", 32'(tbl_cs), 32'd0);
      chk("rst_we", 32'(tbl_we), 32'd0);
      chk("rst_upd_rdy", 32'(upd_rdy), 32'd1);
      chk("rst_lkup_rdy", 32'(lkup_rdy), 32'd1);
      chk("rst_rsp_vld", 32'(lkup_rsp_vld), 32'd0);
      advance();
      rst_n = 1'b1;
      lkup_vld = 1'b1; lkup_pc = pc_of(5);
      sample();
      chk("post_rst_lkup_rdy", 32'(lkup_rdy), 32'd1);
      advance();
      lkup_vld = 1'b0;

      // Single update, counter 1 taken -> 2 at idx 8
      preset(8, 1);
      upd_vld = 1'b1; upd_pc = 32'h8000_0010; upd_taken = 1'b1;
      sample(); chk("t1_c0_cs", 32'(tbl_cs), 32'd0); advance();
      upd_vld = 1'b0;
      sample();
      chk("t1_rd_cs", 32'(tbl_cs), 32'd1);
      chk("t1_rd_we", 32'(tbl_we), 32'd0);
      chk("t1_rd_addr", 32'(tbl_addr), 32'd8);
      advance();
      sample(); chk("t1_cap_cs", 32'(tbl_cs), 32'd0); advance();
      sample();
      chk("t1_wr_cs", 32'(tbl_cs), 32'd1);
      chk("t1_wr_we", 32'(tbl_we), 32'd1);
      chk("t1_wr_addr", 32'(tbl_addr), 32'd8);
      chk("t1_wr_data", 32'(tbl_wdata), 32'd2);
      advance();
      sample();
      chk("t1_idle_cs", 32'(tbl_cs), 32'd0);
      chk("t1_idle_rdy", 32'(upd_rdy), 32'd1);
      advance();
      chk("t1_mem", 32'(mem[8]), 32'd2);

      // Saturation at both ends
      preset(20, 3); preset(21, 0);
      upd_vld = 1'b1; upd_pc = pc_of(20); upd_taken = 1'b1; cyc();
      upd_pc = pc_of(21); upd_taken = 1'b0; cyc();
      drain(0);
      chk("sat_hi", 32'(mem[20]), 32'd3);
      chk("sat_lo", 32'(mem[21]), 32'd0);

      // Back-to-back updates to one index accumulate
      preset(30, 0);
      upd_vld = 1'b1; upd_pc = pc_of(30); upd_taken = 1'b1; cyc();
      upd_pc = pc_of(30); cyc();
      drain(0);
      chk("same_idx", 32'(mem[30]), 32'd2);

      // Starvation forcing under a continuous lookup stream
      for (int k = 0; k <= 10; k++) begin
         drive_lkup_cont();
         upd_vld = (k == 0); upd_pc = pc_of(12); upd_taken = 1'b1;
         sample();
         chk($sformatf("starve_rdy_%0d", k), 32'(lkup_rdy), 32'(rdy_pat[k]));
         advance();
      end
      upd_vld = 1'b0;

      // Fill the queue; the fifth push is refused
      preset(55, 1);
      for (int k = 0; k <= 4; k++) begin
         drive_lkup_cont();
         upd_vld = 1'b1; upd_taken = 1'b1;
         upd_pc = (k == 4) ? pc_of(55) : pc_of(50 + k);
         sample();
         chk($sformatf("fill_rdy_%0d", k), 32'(upd_rdy), (k == 4) ? 32'd0 : 32'd1);
         advance();
      end
      drain(1);
      chk("refused_not_stored", 32'(mem[55]), 32'd1);

      // Reset during the capture cycle discards the in-flight update
      preset(40, 1);
      upd_vld = 1'b1; upd_pc = pc_of(40); upd_taken = 1'b1; cyc();
      upd_vld = 1'b0;
      cyc();
      rst_n = 1'b0;
      #3;
      chk("mid_rst_cs", 32'(tbl_cs), 32'd0);
      chk("mid_rst_we", 32'(tbl_we), 32'd0);
      chk("mid_rst_upd_rdy", 32'(upd_rdy), 32'd1);
      model_reset();
      advance();
      rst_n = 1'b1;
      sample();
      chk("post_rst_cs", 32'(tbl_cs), 32'd0);
      chk("post_rst_we", 32'(tbl_we), 32'd0);
      chk("post_rst_upd_rdy", 32'(upd_rdy), 32'd1);
      advance();
      repeat (4) cyc();
      chk("no_partial_write", 32'(mem[40]), 32'd1);

      // Random mixed traffic
      for (int n = 0; n < 1500; n++) begin
         if (!prev_stall) begin
            lkup_vld = 1'($urandom_range(0, 1));
            lkup_pc  = pc_of(($urandom_range(0, 3) == 0) ? $urandom_range(0, NENT - 1)
                                                        : $urandom_range(0, 7));
         end
         upd_vld   = ($urandom_range(0, 2) == 0);
         upd_pc    = pc_of(($urandom_range(0, 4) == 0) ? $urandom_range(0, NENT - 1)
                                                      : $urandom_range(0, 7));
         upd_taken = 1'($urandom_range(0, 1));
         cyc();
      end
      drain(0);
      for (int i = 0; i < NENT; i++) begin
         chk($sformatf("tbl_final_%0d", i), 32'(mem[i]), 32'(ref_tbl[i]));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
